// File: rtl/ip_multi_lane.sv
// Multi-lane fixed-point neuron engine: a shared input vector times per-lane weights, plus bias.
// Results are rounded, reduced to DW bits and optionally ReLU'd. Define IP_SAT_EN to saturate instead of wrap.

module ip_lane #(
    parameter int DW   = 16,
    parameter int FRAC = 8,
    parameter int ACCW = 40
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          load_i,
    input  logic          acc_en_i,
    input  logic          relu_i,
    input  logic [DW-1:0] bias_i,
    input  logic [DW-1:0] data_i,
    input  logic [DW-1:0] weight_i,
    output logic [DW-1:0] res_o
);
    localparam logic [ACCW-1:0] HALF = ACCW'(1) << (FRAC - 1);

    logic signed [ACCW-1:0]   acc_q, acc_d;
    logic signed [2*DW-1:0]   prod;
    logic signed [ACCW-1:0]   rnd, r;
    logic        [DW-1:0]     red;
`ifndef IP_SAT_EN
    logic                     unused_hi;
`endif

    always_comb begin
        prod  = $signed(data_i) * $signed(weight_i);
        acc_d = acc_q;
        if (load_i)
            acc_d = {{(ACCW-DW-FRAC){bias_i[DW-1]}}, bias_i, {FRAC{1'b0}}};
        else if (acc_en_i)
            acc_d = acc_q + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) acc_q <= '0;
        else         acc_q <= acc_d;
    end

    // Round half up, then drop the fraction with an arithmetic shift.
    always_comb begin
        rnd = acc_q + HALF;
        r   = rnd >>> FRAC;
`ifdef IP_SAT_EN
        if (r[ACCW-1:DW-1] == '0 || r[ACCW-1:DW-1] == '1)
            red = r[DW-1:0];
        else
            red = r[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`else
        red       = r[DW-1:0];
        unused_hi = ^r[ACCW-1:DW];
`endif
        res_o = (relu_i && red[DW-1]) ? '0 : red;
    end
endmodule

module ip_multi_lane #(
    parameter int LANES = 4,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int ACCW  = 40,
    parameter int LB    = 12,
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                start_i,
    input  logic [LB-1:0]       vec_len_i,
    input  logic                relu_en_i,
    input  logic [LANES*DW-1:0] bias_i,
    input  logic                bias_valid_i,
    input  logic [DW-1:0]       data_i,
    input  logic [LANES*DW-1:0] weight_i,
    input  logic                data_valid_i,
    output logic                data_ready_o,
    output logic [DW-1:0]       out_data_o,
    output logic [LW-1:0]       out_lane_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                busy_o,
    output logic                done_o
);
    typedef enum logic [2:0] {IDLE, BIAS, ACC, DRAIN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [LB-1:0]            cnt_q, cnt_d, len_q, len_d;
    logic [LW-1:0]            lane_q, lane_d;
    logic                     relu_q, relu_d;
    logic                     load, acc_en;
    logic [LANES-1:0][DW-1:0] res;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        lane_d  = lane_q;
        relu_d  = relu_q;
        load    = 1'b0;
        acc_en  = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                len_d   = vec_len_i;
                relu_d  = relu_en_i;
                cnt_d   = '0;
                state_d = BIAS;
            end
            BIAS: if (bias_valid_i) begin
                load    = 1'b1;
                lane_d  = '0;
                state_d = (len_q == '0) ? DRAIN : ACC;
            end
            ACC: if (data_valid_i) begin
                acc_en = 1'b1;
                cnt_d  = cnt_q + LB'(1);
                if (cnt_d == len_q) state_d = DRAIN;
            end
            DRAIN: if (out_ready_i) begin
                if (lane_q == LW'(LANES - 1)) begin
                    lane_d  = '0;
                    state_d = DONE;
                end else begin
                    lane_d = lane_q + LW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            lane_q  <= '0;
            relu_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            lane_q  <= lane_d;
            relu_q  <= relu_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        ip_lane #(.DW(DW), .FRAC(FRAC), .ACCW(ACCW)) u_lane (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .load_i   (load),
            .acc_en_i (acc_en),
            .relu_i   (relu_q),
            .bias_i   (bias_i[k*DW +: DW]),
            .data_i   (data_i),
            .weight_i (weight_i[k*DW +: DW]),
            .res_o    (res[k])
        );
    end

    // Accumulators only change in BIAS/ACC, so DRAIN outputs hold while stalled.
    assign data_ready_o = (state_q == ACC);
    assign out_valid_o  = (state_q == DRAIN);
    assign out_lane_o   = lane_q;
    assign out_data_o   = (state_q == DRAIN) ? res[lane_q] : '0;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
endmodule
